// File: rtl/div_if.sv
// Handshake and operand bus between the execute stage (master) and the
// iterative divider (slave).
interface div_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div.sv
// Iterative 32-bit restoring divider for DIV/DIVU.
// One quotient bit per cycle, signed or unsigned operands.
//
// state  | meaning
// FREE   | idle, waiting for start_i
// BYZERO | divisor was zero, result forced to 0
// ON     | 32 shift/subtract iterations in progress
// END    | result_o valid, held until start_i drops
module div (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t      state;
    logic [64:0] dividend;
    logic [31:0] divisor;
    logic [5:0]  cnt;
    logic        sgn_r;
    logic        neg1_r;
    logic        neg2_r;

    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [32:0] t;
    logic [31:0] quo_fin;
    logic [31:0] rem_fin;

    always_comb begin
        abs1 = (bus.signed_div_i && bus.opdata1_i[31]) ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
        abs2 = (bus.signed_div_i && bus.opdata2_i[31]) ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;
        t    = {1'b0, dividend[63:32]} - {1'b0, divisor};
        // Sign fix: quotient negative when operand signs differ, remainder follows dividend.
        quo_fin = (sgn_r && (neg1_r ^ neg2_r)) ? (~dividend[31:0] + 32'd1) : dividend[31:0];
        rem_fin = (sgn_r && neg1_r) ? (~dividend[64:33] + 32'd1) : dividend[64:33];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= FREE;
            dividend     <= '0;
            divisor      <= '0;
            cnt          <= '0;
            sgn_r        <= 1'b0;
            neg1_r       <= 1'b0;
            neg2_r       <= 1'b0;
            bus.result_o <= '0;
            bus.ready_o  <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    bus.ready_o  <= 1'b0;
                    bus.result_o <= '0;
                    if (bus.start_i && !bus.annul_i) begin
                        sgn_r  <= bus.signed_div_i;
                        neg1_r <= bus.opdata1_i[31];
                        neg2_r <= bus.opdata2_i[31];
                        if (bus.opdata2_i == 32'd0) begin
                            state    <= BYZERO;
                            dividend <= '0;
                        end else begin
                            state    <= ON;
                            cnt      <= '0;
                            dividend <= {32'b0, abs1, 1'b0};
                            divisor  <= abs2;
                        end
                    end
                end
                BYZERO: begin
                    state        <= END;
                    dividend     <= '0;
                    bus.result_o <= '0;
                    bus.ready_o  <= 1'b1;
                end
                ON: begin
                    if (bus.annul_i) begin
                        state        <= FREE;
                        bus.ready_o  <= 1'b0;
                        bus.result_o <= '0;
                    end else if (cnt != 6'd32) begin
                        if (t[32])
                            dividend <= {dividend[63:0], 1'b0};
                        else
                            dividend <= {t[31:0], dividend[31:0], 1'b1};
                        cnt <= cnt + 6'd1;
                    end else begin
                        state        <= END;
                        bus.result_o <= {rem_fin, quo_fin};
                        bus.ready_o  <= 1'b1;
                    end
                end
                END: begin
                    if (!bus.start_i) begin
                        state        <= FREE;
                        bus.ready_o  <= 1'b0;
                        bus.result_o <= '0;
                    end
                end
                default: state <= FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Directed and random checks for the iterative divider: results, latency,
// hold/release handshake, annul, divide-by-zero and asynchronous reset.
module tb_div;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    div_if bus ();
    div dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Start a divide and wait for ready_o; lat = edges after the sampling edge.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] res, output int lat);
        @(negedge clk);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (n == 0) begin
                bus.opdata1_i    = $urandom;
                bus.opdata2_i    = $urandom;
                bus.signed_div_i = ~sgn;
            end
            if (bus.ready_o) begin
                lat = n;
                break;
            end
        end
        res = bus.result_o;
    endtask

    task automatic release_op(input string name);
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({name, "_rdy_drop"}, {63'b0, bus.ready_o}, 64'd0);
        chk({name, "_res_drop"}, bus.result_o, 64'd0);
    endtask

    task automatic watch_no_ready(input string name, input int cycles);
        logic seen = 1'b0;
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk);
            #1;
            if (bus.ready_o || bus.result_o != 64'd0) seen = 1'b1;
        end
        chk(name, {63'b0, seen}, 64'd0);
    endtask

    initial begin
        logic [63:0] res;
        int          lat;

        vecs[0] = '{1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 33};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD, 33};
        vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33};
        vecs[3] = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 33};
        vecs[4] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 33};
        vecs[5] = '{1'b0, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF, 33};
        vecs[6] = '{1'b1, 32'd5,          32'd0,        64'h0,                 1};
        vecs[7] = '{1'b0, 32'h80000000,   32'd3,        64'h00000002_2AAAAAAA, 33};
        vecs[8] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 64'h00000000_00000001, 33};

        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;

        #12;
        chk("reset_ready", {63'b0, bus.ready_o}, 64'd0);
        chk("reset_result", bus.result_o, 64'd0);
        #3 rst = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 9; i++) begin
            do_div(vecs[i].sgn, vecs[i].a, vecs[i].b, res, lat);
            chk($sformatf("vec%0d_res", i), res, vecs[i].exp_res);
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
            if (i == 0) begin
                for (int k = 0; k < 5; k++) begin
                    @(posedge clk);
                    #1;
                    chk("hold_res", bus.result_o, vecs[0].exp_res);
                    chk("hold_rdy", {63'b0, bus.ready_o}, 64'd1);
                end
            end
            release_op($sformatf("vec%0d", i));
        end

        // Annul mid-run: start dropped with the annul, no result may appear.
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(negedge clk);
        bus.annul_i = 1'b0;
        watch_no_ready("annul_midrun", 40);

        // start and annul together in FREE must not launch a divide.
        @(negedge clk);
        bus.opdata1_i = 32'd100;
        bus.opdata2_i = 32'd7;
        bus.start_i   = 1'b1;
        bus.annul_i   = 1'b1;
        repeat (3) @(negedge clk);
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        watch_no_ready("annul_free", 40);

        do_div(1'b0, 32'd100, 32'd7, res, lat);
        chk("post_annul_res", res, 64'h00000002_0000000E);
        chk("post_annul_lat", 64'(lat), 64'd33);
        release_op("post_annul");

        // Asynchronous reset between edges, mid-run.
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        repeat (21) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_rdy", {63'b0, bus.ready_o}, 64'd0);
        chk("rst_mid_res", bus.result_o, 64'd0);
        bus.start_i = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        watch_no_ready("rst_mid_idle", 40);

        // Asynchronous reset while a result is held.
        do_div(1'b1, 32'hFFFFFFF9, 32'd2, res, lat);
        chk("pre_rst_end_res", res, 64'hFFFFFFFF_FFFFFFFD);
        #2 rst = 1'b0;
        #1;
        chk("rst_end_rdy", {63'b0, bus.ready_o}, 64'd0);
        chk("rst_end_res", bus.result_o, 64'd0);
        bus.start_i = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        watch_no_ready("rst_end_idle", 5);

        for (int i = 0; i < 1000; i++) begin
            logic        sgn;
            logic [31:0] a, b;
            logic [63:0] exp;
            longint      sa, sb, q, r;
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                b = 32'($urandom_range(1, 20));
                if ($urandom_range(0, 1) == 1) b = ~b + 32'd1;
            end
            if (b == 32'd0) b = 32'd1;
            if (sgn) begin
                sa  = longint'($signed(a));
                sb  = longint'($signed(b));
                q   = sa / sb;
                r   = sa % sb;
                exp = {r[31:0], q[31:0]};
            end else begin
                exp = {a % b, a / b};
            end
            do_div(sgn, a, b, res, lat);
            chk($sformatf("rand%0d_%h_%h_s%0d", i, a, b, sgn), res, exp);
            @(negedge clk);
            bus.start_i = 1'b0;
            @(posedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/div.md
# div

Iterative 32-bit radix-2 divider serving the execute stage for DIV/DIVU. It sits directly upstream of the EX/MEM register. The execute stage holds `start_i` and requests a pipeline stall while `ready_o` is low. When the divider finishes, the execute stage forwards `result_o` as the HI/LO write (`ex_hi`, `ex_lo`, `ex_whilo`) into EX/MEM. Restoring division produces one quotient bit per cycle and supports signed and unsigned operands.

## Interface

No parameters. Data width is fixed at 32 bits.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (`rst == 0` resets immediately, independent of `clk`).
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with `start_i`.
- `opdata1_i`  in  32  dividend; sampled with `start_i`.
- `opdata2_i`  in  32  divisor; sampled with `start_i`.
- `start_i`  in  1  request; the execute stage holds it high until it consumes `ready_o`.
- `annul_i`  in  1  cancel the in-flight or requested division (branch flush / exception).
- `result_o`  out  64  `{remainder, quotient}`; `[63:32]` → HI, `[31:0]` → LO.
- `ready_o`  out  1  `result_o` valid.

## Operation

- State register with four states: FREE, BYZERO, ON, END.
- Datapath:
  - 65-bit shift register `dividend`; `[63:32]` holds the partial remainder, `[31:0]` the quotient/dividend bits.
  - 32-bit `divisor` register.
  - 6-bit `cnt` register.
- **FREE**, with `start_i=1` and `annul_i=0`:
  - If `opdata2_i == 0` → BYZERO.
  - Otherwise → ON, with `cnt=0`, `dividend={32'b0, |op1|, 1'b0}`, `divisor=|op2|`.
  - `|x|` is the two's complement of `x` when `signed_div_i=1` and `x[31]=1`; otherwise `x`.
  - Latch `signed_div_i`, `op1[31]` and `op2[31]` for the sign fix.
- **FREE**, any other input: hold; `ready_o=0`, `result_o=0`.
- **BYZERO** → END unconditionally; `dividend=0`, so the result is `64'h0`.
- **ON**, `annul_i=1` → FREE; `ready_o=0`, `result_o=0`.
- **ON**, `cnt < 32`, one iteration per cycle:
  - Compute `t = {1'b0, dividend[63:32]} - {1'b0, divisor}` (33-bit).
  - If `t[32]=1`: `dividend <= {dividend[63:0], 1'b0}`.
  - Else: `dividend <= {t[31:0], dividend[31:0], 1'b1}`.
  - `cnt++`.
- **ON**, `cnt == 32` → END, registering the final result:
  - Quotient = `dividend[31:0]`; negate it if signed and the latched operand signs differ.
  - Remainder = `dividend[64:33]`; negate it if signed and the latched `op1` sign is 1.
  - Write `result_o={rem, quo}` and set `ready_o=1` on this same edge.
- **END**:
  - Hold `result_o` and keep `ready_o=1` while `start_i=1`.
  - When `start_i=0` → FREE; `ready_o=0`, `result_o=0`.
  - `annul_i` is ignored in END.
- Operand inputs may change after the sampling edge; this has no effect on the running division.
- Signed `0x80000000 / 0xFFFFFFFF` (overflow) → quotient `0x80000000`, remainder `0`. No trap is raised.

## Timing

- Reset values: state=FREE, `ready_o=0`, `result_o=64'h0`, `cnt=0`, `dividend=0`, `divisor=0`.
- Reset asserted mid-operation → all registers return to reset values immediately; there is no partial result.
- Let `start_i` be sampled high in FREE at edge E.
  - Normal path: ON from E; iterations on edges E+1..E+32; `ready_o=1` and `result_o` valid after edge E+33. Latency is 33 cycles.
  - Divide by zero: BYZERO after E; `ready_o=1` and `result_o=0` after edge E+1.
- `ready_o` falls one edge after `start_i` is seen low in END.
- Back-to-back divides:
  - A new start is accepted only from FREE, so there is at least one FREE cycle between results.
  - The execute stage must drop `start_i` for one cycle after consuming `ready_o`.
- `annul_i` and `start_i` both high in FREE → annul wins; the state stays FREE.
- Registered outputs only; there is no combinational path from inputs to outputs.

## Test plan

- **Unsigned divide.** DIVU `100/7`.
  - Expect `result_o=64'h00000002_0000000E` with `ready_o` rising exactly after edge E+33.
  - Hold `start_i` 5 more cycles → outputs stable.
  - Drop `start_i` → `ready_o=0` and `result_o=0` on the next edge.
- **Signed sign rules.**
  - DIV `-7/2` → `result_o=64'hFFFFFFFF_FFFFFFFD`.
  - DIV `7/-2` → `64'h00000001_FFFFFFFD`.
  - DIV `-7/-2` → `64'hFFFFFFFF_00000003`.
- **Corner operands.**
  - DIV `0x80000000/0xFFFFFFFF` → `64'h00000000_80000000`.
  - DIVU `0xFFFFFFFF/1` → `64'h00000000_FFFFFFFF`.
- **Divide by zero.** DIV `5/0` → `ready_o=1` after edge E+1, `result_o=64'h0`.
- **Annul.**
  - Pulse `annul_i` at cycle E+10 → FREE and `ready_o=0`, with no `ready_o` pulse afterward.
  - `start_i` and `annul_i` both high in FREE → no start.
  - A subsequent `100/7` → correct result 33 cycles later.
- **Reset mid-run.**
  - Pull `rst` low asynchronously at E+20 (between clock edges) → outputs go to 0 immediately.
  - After release, with `start_i` low, the unit stays in FREE with outputs 0.
  - Random signed/unsigned operands (1000 cases, divisor ≠ 0) match the reference model's quotient and remainder.
